// File: rtl/u111_pkg.sv
// Purpose      : shared state encoding and bus constants for the U111 local-bus cycle logic.
// Latency      : none (declarations only).
// Backpressure : none (declarations only).
package u111_pkg;

  // Local-bus responder cycle phases.
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WAIT    = 2'd1,
    ST_ACK     = 2'd2,
    ST_RECOVER = 2'd3
  } lb_state_t;

  // PORTSIZE pin encoding seen by the U111 bus-sizing logic.
  localparam logic PORTSIZE_16 = 1'b1;
  localparam logic PORTSIZE_32 = 1'b0;

  // Byte lanes presented to the register file: a 16-bit port lives on D_UU/D_UM.
  localparam logic [3:0] REG_BE_16 = 4'b1100;
  localparam logic [3:0] REG_BE_32 = 4'b1111;

  // Wait-state counter width; bounds WAIT_STATES to 0..15.
  localparam int WS_CNT_W = 4;

endpackage

// File: rtl/u111_ws_counter.sv
// Purpose      : loadable wait-state down-counter with a "last wait cycle" flag.
// Latency      : count visible the cycle after load; terminal is combinational from the count.
// Backpressure : none; en simply freezes the count.
// Ports: core_clk/arst_n clock and async active-low reset; load/load_val preset the count;
//        en decrements (saturating at zero); terminal is high while the count equals 1.
module u111_ws_counter
  import u111_pkg::*;
(
  input  logic                core_clk,
  input  logic                arst_n,
  input  logic                load,
  input  logic [WS_CNT_W-1:0] load_val,
  input  logic                en,
  output logic                terminal
);

  logic [WS_CNT_W-1:0] cnt;

  always_ff @(posedge core_clk or negedge arst_n) begin
    if (!arst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (en && (cnt != '0)) begin
      cnt <= cnt - WS_CNT_W'(1);
    end
  end

  // Terminal at 1 rather than 0 so the acknowledge phase starts exactly WAIT_STATES edges after accept.
  assign terminal = (cnt == WS_CNT_W'(1));

endmodule

// File: rtl/u111_lb_target.sv
// Purpose      : local-bus responder answering U111 TSn cycles for one decoded slave, with a REG_* strobe port.
// Latency      : TACKn low in the cycle WAIT_STATES+1 after the accepting edge; REG_RE next cycle, REG_WE after TACKn.
// Backpressure : none; the register file must honour REG_RE/REG_WE within the programmed wait states.
// Ports: CLK40/RESETn clock and async active-low reset; TSn/SELn/RnW/A_AMIGA/A_HI/D_IN from the U111 side;
//        D_OUT/D_OEn, TACKn/PORTSIZE/TACK_OEn back to the bus (pads live at the top level);
//        REG_ADDR/REG_BE/REG_RE/REG_RDATA/REG_WE/REG_WDATA to the on-card register file.
module u111_lb_target
  import u111_pkg::*;
#(
  parameter int WAIT_STATES = 2,
  parameter bit PORT16      = 1'b1,
  parameter int ADDR_W      = 6
) (
  input  logic              CLK40,
  input  logic              RESETn,
  input  logic              TSn,
  input  logic              SELn,
  input  logic              RnW,
  input  logic [1:0]        A_AMIGA,
  input  logic [ADDR_W-2:0] A_HI,
  input  logic [31:0]       D_IN,
  output logic [31:0]       D_OUT,
  output logic              D_OEn,
  output logic              TACKn,
  output logic              PORTSIZE,
  output logic              TACK_OEn,
  output logic [ADDR_W-1:0] REG_ADDR,
  output logic [3:0]        REG_BE,
  output logic              REG_RE,
  input  logic [31:0]       REG_RDATA,
  output logic              REG_WE,
  output logic [31:0]       REG_WDATA
);

  if ((WAIT_STATES < 0) || (WAIT_STATES > 15)) begin : g_ws_range_err
    $error("u111_lb_target: WAIT_STATES must be in 0..15");
  end

  localparam logic [WS_CNT_W-1:0] WS_LOAD  = WS_CNT_W'(WAIT_STATES);
  localparam logic [31:0]         RD_MASK  = PORT16 ? 32'hFFFF_0000 : 32'hFFFF_FFFF;
  localparam logic                PS_VALUE = PORT16 ? PORTSIZE_16 : PORTSIZE_32;

  lb_state_t         state;
  lb_state_t         state_nxt;
  logic              accept;
  logic              rnw_q;
  logic              ws_done;
  logic [ADDR_W-1:0] addr_nxt;
  logic              unused_a0;

  assign accept    = (state == ST_IDLE) && !TSn && !SELn;
  // A 16-bit port indexes words, so A1 selects the half; a 32-bit port indexes longwords.
  assign addr_nxt  = PORT16 ? {A_HI, A_AMIGA[1]} : {A_HI, 1'b0};
  assign unused_a0 = A_AMIGA[0];
  assign REG_BE    = PORT16 ? REG_BE_16 : REG_BE_32;

  u111_ws_counter u_ws_cnt (
    .core_clk (CLK40),
    .arst_n   (RESETn),
    .load     (accept),
    .load_val (WS_LOAD),
    .en       (state == ST_WAIT),
    .terminal (ws_done)
  );

  always_ff @(posedge CLK40 or negedge RESETn) begin
    if (!RESETn) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          state_nxt = (WAIT_STATES > 0) ? ST_WAIT : ST_ACK;
        end
      end
      ST_WAIT: begin
        if (ws_done) begin
          state_nxt = ST_ACK;
        end
      end
      ST_ACK:     state_nxt = ST_RECOVER;
      ST_RECOVER: state_nxt = ST_IDLE;
      default:    state_nxt = ST_IDLE;
    endcase
  end

  // Pad-facing outputs are registered from the next state so they change cleanly on the clock.
  // TSn arriving in ACK/RECOVER is ignored because accept is only decoded in IDLE.
  always_ff @(posedge CLK40 or negedge RESETn) begin
    if (!RESETn) begin
      TACKn     <= 1'b1;
      TACK_OEn  <= 1'b1;
      D_OEn     <= 1'b1;
      PORTSIZE  <= PORTSIZE_32;
      REG_RE    <= 1'b0;
      REG_WE    <= 1'b0;
      D_OUT     <= '0;
      REG_WDATA <= '0;
      REG_ADDR  <= '0;
      rnw_q     <= 1'b0;
    end else begin
      TACKn    <= (state_nxt != ST_ACK);
      TACK_OEn <= (state_nxt == ST_IDLE);
      PORTSIZE <= (state_nxt == ST_IDLE) ? PORTSIZE_32 : PS_VALUE;
      REG_RE   <= accept && RnW;
      REG_WE   <= (state == ST_ACK) && !rnw_q;

      if (accept) begin
        rnw_q    <= RnW;
        REG_ADDR <= addr_nxt;
        D_OEn    <= !RnW;
      end else if (state_nxt == ST_IDLE) begin
        D_OEn    <= 1'b1;
      end

      // Sample read data on every wait edge so the last one before ACK wins. With zero
      // wait states the only sample is the accept edge, so REG_RDATA must be combinational.
      if (((state == ST_WAIT) && rnw_q) || (accept && RnW && (WAIT_STATES == 0))) begin
        D_OUT <= REG_RDATA & RD_MASK;
      end

      // Write data is held by the U111 through the acknowledge cycle.
      if ((state == ST_ACK) && !rnw_q) begin
        REG_WDATA <= D_IN;
      end
    end
  end

endmodule

// File: tb/tb_u111_lb_target.sv
// Purpose      : randomized scoreboard bench for two u111_lb_target instances (16-bit/2 WS and 32-bit/0 WS).
// Latency      : expectations are derived per transaction from the accept edge and the wait-state count.
// Backpressure : none; the bench models a register file that answers the cycle after REG_RE.
module tb_u111_lb_target;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        ts_n;
  logic        rnw;
  logic [1:0]  sel_n;
  logic [1:0]  a_amiga;
  logic [4:0]  a_hi;
  logic [31:0] d_in;
  logic [31:0] rdata0;
  logic [31:0] rdata1;
  logic [31:0] rd_val0;

  wire [1:0][31:0] d_out;
  wire [1:0][31:0] reg_wdata;
  wire [1:0][5:0]  reg_addr;
  wire [1:0][3:0]  reg_be;
  wire [1:0]       d_oe_n, tack_n, portsize, tack_oe_n, reg_re, reg_we;

  u111_lb_target #(.WAIT_STATES(2), .PORT16(1'b1), .ADDR_W(6)) u_dut16 (
    .CLK40(clk), .RESETn(rst_n), .TSn(ts_n), .SELn(sel_n[0]), .RnW(rnw),
    .A_AMIGA(a_amiga), .A_HI(a_hi), .D_IN(d_in),
    .D_OUT(d_out[0]), .D_OEn(d_oe_n[0]), .TACKn(tack_n[0]), .PORTSIZE(portsize[0]),
    .TACK_OEn(tack_oe_n[0]), .REG_ADDR(reg_addr[0]), .REG_BE(reg_be[0]), .REG_RE(reg_re[0]),
    .REG_RDATA(rdata0), .REG_WE(reg_we[0]), .REG_WDATA(reg_wdata[0])
  );

  u111_lb_target #(.WAIT_STATES(0), .PORT16(1'b0), .ADDR_W(6)) u_dut32 (
    .CLK40(clk), .RESETn(rst_n), .TSn(ts_n), .SELn(sel_n[1]), .RnW(rnw),
    .A_AMIGA(a_amiga), .A_HI(a_hi), .D_IN(d_in),
    .D_OUT(d_out[1]), .D_OEn(d_oe_n[1]), .TACKn(tack_n[1]), .PORTSIZE(portsize[1]),
    .TACK_OEn(tack_oe_n[1]), .REG_ADDR(reg_addr[1]), .REG_BE(reg_be[1]), .REG_RE(reg_re[1]),
    .REG_RDATA(rdata1), .REG_WE(reg_we[1]), .REG_WDATA(reg_wdata[1])
  );

  // Register file behind the 16-bit target: data valid only in the cycle after REG_RE.
  always @(posedge clk) rdata0 <= reg_re[0] ? rd_val0 : $urandom;

  typedef struct {
    int          inst;
    int          e;
    bit          rd;
    logic [5:0]  addr;
    logic [31:0] data;
  } txn_t;

  txn_t ack_q[$];
  txn_t re_q[$];
  txn_t we_q[$];
  txn_t mt;

  int cyc = 0;
  int n_checks = 0;
  int n_err = 0;
  bit mon_en = 1'b0;
  int lo[2] = '{-100, -100};
  int hi[2] = '{-100, -100};
  bit win_rd[2] = '{1'b0, 1'b0};

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int ws_of(input int i);
    return (i == 0) ? 2 : 0;
  endfunction

  function automatic bit p16_of(input int i);
    return (i == 0);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @cycle %0d: got %h, required %h", name, cyc, act, exp);
    end
  endtask

  task automatic check_reset_values();
    for (int i = 0; i < 2; i++) begin
      chk("rst_tackn", tack_n[i], 1'b1);
      chk("rst_tack_oen", tack_oe_n[i], 1'b1);
      chk("rst_d_oen", d_oe_n[i], 1'b1);
      chk("rst_portsize", portsize[i], 1'b0);
      chk("rst_reg_re", reg_re[i], 1'b0);
      chk("rst_reg_we", reg_we[i], 1'b0);
      chk("rst_d_out", d_out[i], 32'h0);
      chk("rst_wdata", reg_wdata[i], 32'h0);
      chk("rst_addr", reg_addr[i], 6'h0);
    end
  endtask

  // One complete bus cycle to target i; returns during its RECOVER cycle so the
  // next call can start a back-to-back TSn in the following IDLE cycle.
  task automatic issue(input int i, input bit rd, input logic [4:0] ahi, input logic [1:0] aam,
                       input logic [31:0] val, input bit junk);
    txn_t t;
    @(posedge clk); #1;
    ts_n = 1'b0; sel_n = (i == 0) ? 2'b10 : 2'b01; rnw = rd;
    a_hi = ahi; a_amiga = aam; d_in = val;
    if (i == 0) rd_val0 = val; else rdata1 = val;
    @(posedge clk); #1;
    t.inst = i; t.e = cyc; t.rd = rd;
    t.addr = p16_of(i) ? {ahi, aam[1]} : {ahi, 1'b0};
    t.data = (rd && p16_of(i)) ? {val[31:16], 16'h0000} : val;
    lo[i] = cyc; hi[i] = cyc + ws_of(i) + 1; win_rd[i] = rd;
    ack_q.push_back(t);
    if (rd) re_q.push_back(t); else we_q.push_back(t);
    ts_n = 1'b1; sel_n = 2'b11;
    a_hi = 5'($urandom); a_amiga = 2'($urandom); rnw = 1'($urandom);
    repeat (ws_of(i)) @(posedge clk);
    #1;
    if (junk) begin
      ts_n = 1'b0; sel_n = (i == 0) ? 2'b10 : 2'b01;
    end
    @(posedge clk); #1;
  endtask

  task automatic idle_cycles(input int n, input bit missel);
    for (int k = 0; k < n; k++) begin
      @(posedge clk); #1;
      ts_n = missel ? 1'($urandom) : 1'b1;
      sel_n = 2'b11;
      d_in = $urandom;
    end
  endtask

  task automatic reset_mid_wait();
    txn_t t;
    @(posedge clk); #1;
    ts_n = 1'b0; sel_n = 2'b10; rnw = 1'b1; a_hi = 5'h0A; a_amiga = 2'b01; rd_val0 = 32'hDEAD_BEEF;
    @(posedge clk); #1;
    t.inst = 0; t.e = cyc; t.rd = 1'b1; t.addr = 6'h14; t.data = 32'h0;
    re_q.push_back(t);
    lo[0] = cyc; hi[0] = cyc + 3; win_rd[0] = 1'b1;
    ts_n = 1'b1; sel_n = 2'b11;
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    lo[0] = -100; hi[0] = -100;
    check_reset_values();
    repeat (3) @(posedge clk);
    #1;
    check_reset_values();
    rst_n = 1'b1;
  endtask

  // Monitor: pops the scoreboard whenever a DUT presents a strobe or acknowledge.
  always @(negedge clk) begin
    if (mon_en && rst_n) begin
      for (int i = 0; i < 2; i++) begin
        bit inw;
        inw = (cyc >= lo[i]) && (cyc <= hi[i]);
        chk("tack_oen", tack_oe_n[i], !inw);
        chk("d_oen", d_oe_n[i], !(inw && win_rd[i]));
        if (inw) chk("portsize", portsize[i], p16_of(i));
        chk("reg_be", reg_be[i], p16_of(i) ? 4'b1100 : 4'b1111);

        if (!tack_n[i]) begin
          if ((ack_q.size() == 0) || (ack_q[0].inst != i)) begin
            chk("ack_unexpected", tack_n[i], 1'b1);
          end else begin
            mt = ack_q.pop_front();
            chk("ack_cycle", cyc, mt.e + ws_of(i));
            chk("ack_addr", reg_addr[i], mt.addr);
            if (mt.rd) chk("ack_dout", d_out[i], mt.data);
          end
        end else if ((ack_q.size() != 0) && (ack_q[0].inst == i) && (cyc >= ack_q[0].e + ws_of(i))) begin
          mt = ack_q.pop_front();
          chk("ack_missing", tack_n[i], 1'b0);
        end

        if (reg_re[i]) begin
          if ((re_q.size() == 0) || (re_q[0].inst != i)) begin
            chk("re_unexpected", reg_re[i], 1'b0);
          end else begin
            mt = re_q.pop_front();
            chk("re_cycle", cyc, mt.e);
            chk("re_addr", reg_addr[i], mt.addr);
          end
        end

        if (reg_we[i]) begin
          if ((we_q.size() == 0) || (we_q[0].inst != i)) begin
            chk("we_unexpected", reg_we[i], 1'b0);
          end else begin
            mt = we_q.pop_front();
            chk("we_cycle", cyc, mt.e + ws_of(i) + 1);
            chk("we_data", reg_wdata[i], mt.data);
            chk("we_addr", reg_addr[i], mt.addr);
          end
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation still running, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b1; ts_n = 1'b1; sel_n = 2'b11; rnw = 1'b1;
    a_hi = '0; a_amiga = '0; d_in = '0; rd_val0 = '0; rdata1 = '0;
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_values();
    rst_n = 1'b1;
    mon_en = 1'b1;

    issue(0, 1'b1, 5'h1F, 2'b10, 32'hA5A5_0000, 1'b0);
    issue(1, 1'b0, 5'h03, 2'b01, 32'h1234_5678, 1'b0);
    idle_cycles(4, 1'b1);
    issue(0, 1'b1, 5'h05, 2'b00, 32'h0BAD_F00D, 1'b1);
    issue(0, 1'b1, 5'h06, 2'b11, 32'hCAFE_1234, 1'b0);
    issue(1, 1'b1, 5'h11, 2'b10, 32'h8765_4321, 1'b1);
    issue(0, 1'b0, 5'h1F, 2'b11, 32'h5555_AAAA, 1'b0);
    idle_cycles(2, 1'b0);

    reset_mid_wait();
    issue(0, 1'b1, 5'h0A, 2'b01, 32'h0F0F_F0F0, 1'b0);

    for (int k = 0; k < 300; k++) begin
      int i;
      i = $urandom_range(0, 1);
      if ($urandom_range(0, 5) == 0) begin
        idle_cycles($urandom_range(1, 3), 1'b1);
      end else begin
        issue(i, 1'($urandom), 5'($urandom), 2'($urandom), $urandom, ($urandom_range(0, 3) == 0));
      end
    end
    idle_cycles(5, 1'b0);

    chk("ack_q_drained", ack_q.size(), 0);
    chk("re_q_drained", re_q.size(), 0);
    chk("we_q_drained", we_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
